i2c_scl_phase_gen: RTL and testbench
====================================

// Module: i2c_scl_phase_gen
// PURPOSE
//  Parametrised successor to the fixed-rate I2C clock-enable divider.
//  Runtime-programmable SCL rate; four one-cycle phase strobes per SCL period (fall, drive, rise, sample).
//  Supports slave clock stretching with timeout and a fast-start path to the first sample point.
//  Sits between the system clock domain and the I2C byte/bit controller, which consumes the strobes and scl_low_o.
// PARAMETERS
//  DIV_W        16  width of div_cfg; quarter-period Q = div_cfg >> 2
//  SYNC_STAGES  2   flops in the scl_in synchroniser (>= 2)
//  STRETCH_W    20  width of the stretch counter
//  STRETCH_MAX  0   stretch timeout in clk cycles; 0 = timeout disabled
// PORTS
//  clk              in   1        system clock
//  rst_n            in   1        asynchronous, active-low reset
//  scl_en           in   1        run request from the bit controller
//  div_cfg          in   DIV_W    SCL period setting; Q = div_cfg>>2; Q<2 treated as 2
//  scl_in           in   1        SCL pad input (async)
//  scl_low_o        out  1        1 = drive SCL low (open-drain enable)
//  tick_fall        out  1        pulse: SCL driven low (entry LOW1)
//  tick_drive       out  1        pulse: mid-low, SDA may change (entry LOW2)
//  tick_rise        out  1        pulse: SCL released (entry HIGH_WAIT)
//  tick_sample      out  1        pulse: mid-high, sample SDA / issue START-STOP (entry HIGH2)
//  stretch_o        out  1        1 while in HIGH_WAIT
//  stretch_timeout  out  1        pulse: stretch exceeded STRETCH_MAX
//  busy             out  1        1 in any state except IDLE
// BEHAVIOUR
//  Everything clocked on clk; every flop resets asynchronously on rst_n=0. All outputs are registered.
//  Reset values: every output 0, state IDLE, counters 0, synchroniser flops 1.
//  States: IDLE, LOW1, LOW2, HIGH_WAIT, HIGH1, HIGH2, FAULT. Each tick_* output is high for exactly one cycle, on state entry.
//  IDLE: scl_low_o=0. Rising edge of scl_en (registered scl_en_d=0, scl_en=1 at posedge k) -> HIGH2, tick_sample=1 after posedge k (fast start).
//  HIGH2: counts Q cycles, then -> LOW1 with tick_fall.
//  LOW1: counts Q cycles, then -> LOW2 with tick_drive.
//  LOW2: counts Q cycles, then -> HIGH_WAIT with tick_rise.
//  HIGH_WAIT: wait for synchronised scl_in=1; counter frozen; one cycle after scl_sync=1 -> HIGH1 (no strobe).
//  HIGH1: counts Q cycles, then -> HIGH2 with tick_sample.
//  scl_low_o=1 in LOW1 and LOW2 only.
//  Q sampled from div_cfg on each entry to LOW1 and held for the whole period, so changes are glitch-free at period boundaries.
//  Nominal period, tick_fall to tick_fall, with no stretch: 4Q + SYNC_STAGES + 1 cycles.
//  Stretch counter: cleared on entry to HIGH_WAIT, increments each cycle in HIGH_WAIT, saturates at the all-ones value.
//  Timeout: if STRETCH_MAX!=0 and the stretch count reaches STRETCH_MAX -> FAULT, stretch_timeout pulse; scl_low_o=0 in FAULT.
//  FAULT: held until scl_en=0, then -> IDLE. A new scl_en rising edge is required to restart.
//  scl_en=0 in any non-IDLE state -> IDLE on the next edge, scl_low_o released. No strobe is issued on that cycle.
//  Simultaneous events: a scl_en deassert beats a phase transition or a timeout in the same cycle.
//  scl_en held high across IDLE (after abort) does not restart; only a 0->1 edge starts.
//  Reset mid-operation: immediate return to IDLE, SCL released, no strobes.
// TESTING
//  T1: div_cfg=40, scl_in=~scl_low_o, scl_en 0->1 -> tick_sample 1 cycle later; tick_fall 10 cycles later; period 43 cycles.
//  T2: div_cfg=4 (Q=1) -> clamped to Q=2; period 11 cycles; each strobe occurs exactly once per period, in the order fall, drive, rise, sample.
//  T3: after tick_rise, hold scl_in=0 for 100 cycles -> stretch_o=1 throughout; HIGH1 entered SYNC_STAGES+1 cycles after release; tick_sample Q cycles later.
//  T4: STRETCH_MAX=50, scl_in stuck 0 -> stretch_timeout pulse 50 cycles after tick_rise; FAULT, busy=1, scl_low_o=0; scl_en=0 -> IDLE, busy=0.
//  T5: change div_cfg 40->80 mid-LOW2 -> current period keeps Q=10; next period starts at tick_fall with Q=20.
//  T6: assert rst_n=0 in LOW1, and separately drop scl_en in LOW2 -> all outputs 0 next cycle; state IDLE; no strobe emitted.

Source files
------------

// File: rtl/i2c_scl_phase_gen.sv
// i2c_scl_phase_gen: programmable SCL phase generator for an I2C master.
// Walks SCL through four quarter-period phases and emits a one-cycle strobe
// on entry to each. Supports slave clock stretching with an optional timeout,
// and a fast start that goes straight to the first sample point.
module i2c_scl_phase_gen #(
  parameter int          DIV_W       = 16,
  parameter int          SYNC_STAGES = 2,
  parameter int          STRETCH_W   = 20,
  parameter int unsigned STRETCH_MAX = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_en,
  input  logic [DIV_W-1:0] div_cfg,
  input  logic             scl_in,
  output logic             scl_low_o,
  output logic             tick_fall,
  output logic             tick_drive,
  output logic             tick_rise,
  output logic             tick_sample,
  output logic             stretch_o,
  output logic             stretch_timeout,
  output logic             busy
);
  localparam int QW    = DIV_W - 2;
  localparam bit TO_EN = (STRETCH_MAX != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_LOW1, S_LOW2, S_HWAIT, S_HIGH1, S_HIGH2, S_FAULT
  } state_t;

  state_t                 r_state;
  logic                   r_en_d;
  logic [QW-1:0]          r_q;
  logic [QW-1:0]          r_cnt;
  logic [STRETCH_W-1:0]   r_str;
  logic [SYNC_STAGES-1:0] r_sync;

  logic [QW-1:0]        w_q_raw;
  logic [QW-1:0]        w_q_cfg;
  logic                 w_q_done;
  logic                 w_scl_sync;
  logic [STRETCH_W-1:0] w_str_nxt;
  logic                 w_timeout;

  // Quarter period from the config, clamped so each phase lasts >= 2 cycles.
  assign w_q_raw    = div_cfg[DIV_W-1:2];
  assign w_q_cfg    = (w_q_raw < QW'(2)) ? QW'(2) : w_q_raw;
  // Phase counter is loaded with 1 on entry, so a phase lasts exactly r_q cycles.
  assign w_q_done   = (r_cnt == r_q);
  assign w_scl_sync = r_sync[SYNC_STAGES-1];
  assign w_str_nxt  = (&r_str) ? r_str : r_str + 1'b1;
  assign w_timeout  = TO_EN && (w_str_nxt >= STRETCH_W'(STRETCH_MAX));

  // SCL pad synchroniser; resets to 1 (released bus).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '1;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], scl_in};
  end

  // Phase FSM with registered outputs; a scl_en drop overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_en_d          <= 1'b0;
      r_q             <= '0;
      r_cnt           <= '0;
      r_str           <= '0;
      scl_low_o       <= 1'b0;
      tick_fall       <= 1'b0;
      tick_drive      <= 1'b0;
      tick_rise       <= 1'b0;
      tick_sample     <= 1'b0;
      stretch_o       <= 1'b0;
      stretch_timeout <= 1'b0;
      busy            <= 1'b0;
    end else begin
      r_en_d          <= scl_en;
      tick_fall       <= 1'b0;
      tick_drive      <= 1'b0;
      tick_rise       <= 1'b0;
      tick_sample     <= 1'b0;
      stretch_timeout <= 1'b0;
      if (r_state != S_IDLE && !scl_en) begin
        r_state   <= S_IDLE;
        scl_low_o <= 1'b0;
        stretch_o <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (scl_en && !r_en_d) begin
              // Fast start: jump straight to the sample point.
              r_state     <= S_HIGH2;
              r_q         <= w_q_cfg;
              r_cnt       <= QW'(1);
              tick_sample <= 1'b1;
              busy        <= 1'b1;
            end
          end
          S_HIGH2: begin
            if (w_q_done) begin
              // Period boundary: pick up a new rate here only.
              r_state   <= S_LOW1;
              r_q       <= w_q_cfg;
              r_cnt     <= QW'(1);
              tick_fall <= 1'b1;
              scl_low_o <= 1'b1;
            end else r_cnt <= r_cnt + 1'b1;
          end
          S_LOW1: begin
            if (w_q_done) begin
              r_state    <= S_LOW2;
              r_cnt      <= QW'(1);
              tick_drive <= 1'b1;
            end else r_cnt <= r_cnt + 1'b1;
          end
          S_LOW2: begin
            if (w_q_done) begin
              r_state   <= S_HWAIT;
              r_str     <= '0;
              tick_rise <= 1'b1;
              scl_low_o <= 1'b0;
              stretch_o <= 1'b1;
            end else r_cnt <= r_cnt + 1'b1;
          end
          S_HWAIT: begin
            // Phase counter frozen while a slave may be holding SCL low.
            r_str <= w_str_nxt;
            if (w_scl_sync) begin
              r_state   <= S_HIGH1;
              r_cnt     <= QW'(1);
              stretch_o <= 1'b0;
            end else if (w_timeout) begin
              r_state         <= S_FAULT;
              stretch_o       <= 1'b0;
              stretch_timeout <= 1'b1;
            end
          end
          S_HIGH1: begin
            if (w_q_done) begin
              r_state     <= S_HIGH2;
              r_cnt       <= QW'(1);
              tick_sample <= 1'b1;
            end else r_cnt <= r_cnt + 1'b1;
          end
          S_FAULT: begin
            // Parked with SCL released until scl_en drops.
            scl_low_o <= 1'b0;
          end
          default: begin
            r_state   <= S_IDLE;
            scl_low_o <= 1'b0;
            stretch_o <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_scl_phase_gen.sv
// Bench for i2c_scl_phase_gen: expected strobes are queued with their cycle
// stamps by the stimulus; a negedge monitor pops and compares them.
module tb_i2c_scl_phase_gen;
  logic clk = 1'b0;
  logic rst_n, en_a, en_b, hold_a, hold_b;
  logic [15:0] div_cfg;
  logic scl_a, scl_b;
  logic low_a, tf_a, td_a, tr_a, ts_a, st_a, to_a, busy_a;
  logic low_b, tf_b, td_b, tr_b, ts_b, st_b, to_b, busy_b;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct { int kind; int cyc; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  string kname [5] = '{"fall", "drive", "rise", "sample", "timeout"};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Open-drain loopback, optionally held low by a "slave".
  assign scl_a = ~low_a & ~hold_a;
  assign scl_b = ~low_b & ~hold_b;

  i2c_scl_phase_gen u_dut (
    .clk(clk), .rst_n(rst_n), .scl_en(en_a), .div_cfg(div_cfg), .scl_in(scl_a),
    .scl_low_o(low_a), .tick_fall(tf_a), .tick_drive(td_a), .tick_rise(tr_a),
    .tick_sample(ts_a), .stretch_o(st_a), .stretch_timeout(to_a), .busy(busy_a));

  i2c_scl_phase_gen #(.STRETCH_MAX(50)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .scl_en(en_b), .div_cfg(div_cfg), .scl_in(scl_b),
    .scl_low_o(low_b), .tick_fall(tf_b), .tick_drive(td_b), .tick_rise(tr_b),
    .tick_sample(ts_b), .stretch_o(st_b), .stretch_timeout(to_b), .busy(busy_b));

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int dut, input int kind, input int c);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    if (dut == 0) qa.push_back(e);
    else          qb.push_back(e);
  endtask

  // One unstretched period starting at tick_fall cycle f.
  task automatic push_period(input int dut, input int f, input int q);
    push(dut, 0, f);
    push(dut, 1, f + q);
    push(dut, 2, f + 2*q);
    push(dut, 3, f + 3*q + 3);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic sb_pop(input int dut, input int kind);
    exp_t e;
    bit   empty;
    total++;
    empty = (dut == 0) ? (qa.size() == 0) : (qb.size() == 0);
    if (empty) begin
      bad++;
      $display("FAIL sb%0d_unexpected: got %s at cyc %0d, expected none", dut, kname[kind], cyc);
    end else begin
      if (dut == 0) e = qa.pop_front();
      else          e = qb.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        bad++;
        $display("FAIL sb%0d_event: got %s at cyc %0d, expected %s at cyc %0d",
                 dut, kname[kind], cyc, kname[e.kind], e.cyc);
      end
    end
  endtask

  // Monitor: every strobe must match the head of its scoreboard queue.
  always @(negedge clk) begin
    logic [4:0] ev_a, ev_b;
    ev_a = {to_a, ts_a, tr_a, td_a, tf_a};
    ev_b = {to_b, ts_b, tr_b, td_b, tf_b};
    for (int i = 0; i < 5; i++) if (ev_a[i]) sb_pop(0, i);
    for (int i = 0; i < 5; i++) if (ev_b[i]) sb_pop(1, i);
  end

  function automatic int outs_a();
    return int'({low_a, tf_a, td_a, tr_a, ts_a, st_a, to_a, busy_a});
  endfunction
  function automatic int outs_b();
    return int'({low_b, tf_b, td_b, tr_b, ts_b, st_b, to_b, busy_b});
  endfunction

  initial begin
    int k, f, r;
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; hold_a = 1'b0; hold_b = 1'b0;
    div_cfg = 16'd40;
    repeat (3) @(negedge clk);
    check("reset_outs_a", outs_a(), 0);
    check("reset_outs_b", outs_b(), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_outs_a", outs_a(), 0);

    // T1: Q=10, fast start, 43-cycle period.
    k = cyc + 1; en_a = 1'b1;
    push(0, 3, k);
    for (int p = 0; p < 3; p++) push_period(0, k + 10 + 43*p, 10);
    wait_until(k + 1);
    check("t1_busy", busy_a, 1);
    wait_until(k + 15);
    check("t1_low1_scl_low", low_a, 1);
    wait_until(k + 131);
    en_a = 1'b0;
    @(negedge clk);
    check("t1_abort_busy", busy_a, 0);
    check("t1_drained", qa.size(), 0);
    repeat (3) @(negedge clk);

    // T2: div=4 clamps to Q=2; abort collides with the next fall.
    div_cfg = 16'd4;
    k = cyc + 1; en_a = 1'b1;
    push(0, 3, k);
    for (int p = 0; p < 3; p++) push_period(0, k + 2 + 11*p, 2);
    wait_until(k + 34);
    en_a = 1'b0;
    @(negedge clk);
    check("t2_abort_beats_fall", outs_a(), 0);
    check("t2_drained", qa.size(), 0);
    repeat (3) @(negedge clk);

    // T3: slave stretches SCL for 100 cycles after tick_rise.
    div_cfg = 16'd40;
    k = cyc + 1; en_a = 1'b1;
    f = k + 10; r = f + 20;
    push(0, 3, k); push(0, 0, f); push(0, 1, f + 10); push(0, 2, r);
    push(0, 3, r + 113);
    wait_until(f + 5);
    hold_a = 1'b1;
    wait_until(r);
    begin
      int nbad = 0;
      repeat (100) begin if (st_a !== 1'b1) nbad++; @(negedge clk); end
      hold_a = 1'b0;
      repeat (3) begin if (st_a !== 1'b1) nbad++; @(negedge clk); end
      check("t3_stretch_held", nbad, 0);
    end
    check("t3_high1_entry", st_a, 0);
    wait_until(r + 115);
    en_a = 1'b0;
    @(negedge clk);
    check("t3_abort_busy", busy_a, 0);
    check("t3_drained", qa.size(), 0);
    repeat (3) @(negedge clk);

    // T4: SCL stuck low on the timeout instance.
    hold_b = 1'b1;
    k = cyc + 1; en_b = 1'b1;
    push(1, 3, k); push(1, 0, k + 10); push(1, 1, k + 20); push(1, 2, k + 30);
    push(1, 4, k + 80);
    wait_until(k + 79);
    check("t4_pre_stretch", st_b, 1);
    wait_until(k + 80);
    check("t4_fault_busy", busy_b, 1);
    check("t4_fault_scl", low_b, 0);
    check("t4_fault_stretch", st_b, 0);
    wait_until(k + 81);
    check("t4_timeout_pulse", to_b, 0);
    wait_until(k + 85);
    check("t4_fault_held", busy_b, 1);
    en_b = 1'b0;
    @(negedge clk);
    check("t4_idle_busy", busy_b, 0);
    check("t4_drained", qb.size(), 0);
    hold_b = 1'b0;
    repeat (3) @(negedge clk);

    // T5: rate change mid-LOW2 lands at the next tick_fall; then T6b abort in LOW2.
    div_cfg = 16'd40;
    k = cyc + 1; en_a = 1'b1;
    f = k + 10;
    push(0, 3, k);
    push_period(0, f, 10);
    push_period(0, f + 43, 20);
    push(0, 0, f + 126); push(0, 1, f + 146);
    wait_until(f + 15);
    div_cfg = 16'd80;
    wait_until(f + 150);
    check("t6b_low2_scl_low", low_a, 1);
    en_a = 1'b0;
    @(negedge clk);
    check("t6b_abort_outs", outs_a(), 0);
    check("t5_drained", qa.size(), 0);
    repeat (3) @(negedge clk);

    // T6a: reset asserted in LOW1.
    div_cfg = 16'd40;
    k = cyc + 1; en_a = 1'b1;
    f = k + 10;
    push(0, 3, k); push(0, 0, f);
    wait_until(f + 3);
    check("t6a_low1_scl_low", low_a, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6a_reset_outs", outs_a(), 0);
    en_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("t6a_post_reset_outs", outs_a(), 0);
    check("t6a_drained", qa.size(), 0);

    repeat (5) @(negedge clk);
    check("final_qa_empty", qa.size(), 0);
    check("final_qb_empty", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
